// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   sr_w_f(max_data)  : frame register width (data + parity + stop)
//   len_w_f(max_data) : width of a field able to hold 0..max_data
//   par_mode_e        : parity sense selected by ohel (even / odd)
//   frame_status_t    : per-frame error flags {perr, ferr}
package uart_pkg;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_mode_e;

  typedef struct packed {
    logic perr;
    logic ferr;
  } frame_status_t;

  function automatic int unsigned sr_w_f(input int unsigned max_data);
    return max_data + 2;
  endfunction

  function automatic int unsigned len_w_f(input int unsigned max_data);
    return $clog2(max_data + 1);
  endfunction

endpackage

// File: rtl/uart_rx_align.sv
// Field extraction and checking of an already right-aligned frame.
//   aligned_i : frame shifted so data starts at bit 0 (parity, then stop above it)
//   len_i     : effective data length L (already clamped)
//   pen_i     : parity present
//   ohel_i    : parity sense (PAR_EVEN / PAR_ODD)
//   data_o    : aligned_i[L-1:0], zero above L
//   status_o  : {perr, ferr} for this frame
module uart_rx_align
  import uart_pkg::*;
#(
  parameter  int unsigned MAX_DATA = 8,
  localparam int unsigned SR_W     = sr_w_f(MAX_DATA),
  localparam int unsigned LEN_W    = len_w_f(MAX_DATA)
) (
  input  logic [SR_W-1:0]     aligned_i,
  input  logic [LEN_W-1:0]    len_i,
  input  logic                pen_i,
  input  logic                ohel_i,
  output logic [MAX_DATA-1:0] data_o,
  output frame_status_t       status_o
);

  logic [31:0] len_u;
  logic [31:0] stop_u;
  logic        parity;
  logic        stop;

  always_comb begin
    len_u  = 32'(len_i);
    // stop bit sits directly above the parity bit, or above the data when pen=0
    stop_u = len_u + 32'(pen_i);
    data_o = '0;
    parity = 1'b0;
    stop   = 1'b0;
    for (int unsigned i = 0; i < MAX_DATA; i++) begin
      if (i < len_u) data_o[i] = aligned_i[i];
    end
    for (int unsigned i = 0; i < SR_W; i++) begin
      if (i == len_u)  parity = aligned_i[i];
      if (i == stop_u) stop   = aligned_i[i];
    end
    status_o.perr = pen_i & (^data_o ^ parity ^ (ohel_i == PAR_ODD));
    status_o.ferr = ~stop;
  end

endmodule

// File: rtl/uart_rx_deframe.sv
// Two-stage UART receive deframer with a single host holding register.
//   clk, reset  : clock, synchronous active-high reset
//   frame_done  : strobe, frame_in holds a complete frame
//   frame_in    : raw frame, received bits in the top N bits
//   data_len    : data bits per frame (clamped to [MIN_DATA, MAX_DATA])
//   pen, ohel   : parity enable, odd(1)/even(0) parity
//   rd_strobe   : host read of rx_data
//   rx_data     : aligned data of the held frame
//   rx_ready    : holding register contains unread data
//   perr, ferr  : parity / framing error of the held frame
//   ovf         : sticky overrun (frame loaded over unread data)
module uart_rx_deframe
  import uart_pkg::*;
#(
  parameter  int unsigned MAX_DATA = 8,
  parameter  int unsigned MIN_DATA = 5,
  localparam int unsigned SR_W     = sr_w_f(MAX_DATA),
  localparam int unsigned LEN_W    = len_w_f(MAX_DATA)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_done,
  input  logic [SR_W-1:0]     frame_in,
  input  logic [LEN_W-1:0]    data_len,
  input  logic                pen,
  input  logic                ohel,
  input  logic                rd_strobe,
  output logic [MAX_DATA-1:0] rx_data,
  output logic                rx_ready,
  output logic                perr,
  output logic                ferr,
  output logic                ovf
);

  // stage 1 next-state
  logic [31:0]      len_u;
  logic [31:0]      n_u;
  logic [31:0]      shift_u;
  logic [SR_W-1:0]  aligned_d;
  logic [LEN_W-1:0] len_d;

  // stage 1 registers
  logic [SR_W-1:0]  aligned_q;
  logic [LEN_W-1:0] len_q;
  logic             pen_q;
  logic             ohel_q;
  logic             v1_q;

  // holding register
  logic [MAX_DATA-1:0] rx_data_q;
  logic                rx_ready_q;
  logic                perr_q;
  logic                ferr_q;
  logic                ovf_q;

  logic [MAX_DATA-1:0] data_d;
  frame_status_t       status_d;

  always_comb begin
    len_u = 32'(data_len);
    if (len_u < MIN_DATA)      len_u = MIN_DATA;
    else if (len_u > MAX_DATA) len_u = MAX_DATA;
    n_u       = len_u + 32'(pen) + 32'd1;
    shift_u   = SR_W - n_u;
    aligned_d = frame_in >> shift_u;
    len_d     = len_u[LEN_W-1:0];
  end

  uart_rx_align #(
    .MAX_DATA(MAX_DATA)
  ) u_align (
    .aligned_i(aligned_q),
    .len_i    (len_q),
    .pen_i    (pen_q),
    .ohel_i   (ohel_q),
    .data_o   (data_d),
    .status_o (status_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      aligned_q  <= '0;
      len_q      <= '0;
      pen_q      <= 1'b0;
      ohel_q     <= 1'b0;
      v1_q       <= 1'b0;
      rx_data_q  <= '0;
      rx_ready_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      v1_q <= frame_done;
      if (frame_done) begin
        aligned_q <= aligned_d;
        len_q     <= len_d;
        pen_q     <= pen;
        ohel_q    <= ohel;
      end
      if (v1_q) begin
        rx_data_q  <= data_d;
        perr_q     <= status_d.perr;
        ferr_q     <= status_d.ferr;
        rx_ready_q <= 1'b1;
        // ovf=1 implies rx_ready=1, so this also keeps a standing overrun sticky
        ovf_q      <= rx_ready_q & ~rd_strobe;
      end else if (rd_strobe && rx_ready_q) begin
        rx_ready_q <= 1'b0;
        ovf_q      <= 1'b0;
      end
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_ready = rx_ready_q;
  assign perr     = perr_q;
  assign ferr     = ferr_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_uart_rx_deframe.sv
module tb_uart_rx_deframe;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_done;
  logic [9:0] frame_in;
  logic [3:0] data_len;
  logic       pen;
  logic       ohel;
  logic       rd_strobe;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       perr;
  logic       ferr;
  logic       ovf;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  uart_rx_deframe #(
    .MAX_DATA(8),
    .MIN_DATA(5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .frame_done(frame_done),
    .frame_in  (frame_in),
    .data_len  (data_len),
    .pen       (pen),
    .ohel      (ohel),
    .rd_strobe (rd_strobe),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .perr      (perr),
    .ferr      (ferr),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame_done cycle; settings are scrambled afterwards to show they were captured.
  task automatic send(input logic [9:0] f, input logic [3:0] l, input logic p, input logic o);
    frame_in   = f;
    data_len   = l;
    pen        = p;
    ohel       = o;
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    frame_in   = '0;
    data_len   = 4'd0;
    pen        = ~p;
    ohel       = ~o;
  endtask

  task automatic do_read();
    rd_strobe = 1'b1;
    tick();
    rd_strobe = 1'b0;
  endtask

  initial begin
    reset = 1'b1; frame_done = 1'b0; frame_in = '0; data_len = 4'd8;
    pen = 1'b0; ohel = 1'b0; rd_strobe = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_data",  32'(rx_data),  32'h0);
    check("rst_ready", 32'(rx_ready), 32'h0);
    check("rst_perr",  32'(perr),     32'h0);
    check("rst_ferr",  32'(ferr),     32'h0);
    check("rst_ovf",   32'(ovf),      32'h0);

    // 8-bit, even parity
    send(10'h2A5, 4'd8, 1'b1, 1'b0);
    check("lat_t1_ready", 32'(rx_ready), 32'h0);
    tick();
    check("v1_data",  32'(rx_data),  32'hA5);
    check("v1_ready", 32'(rx_ready), 32'h1);
    check("v1_perr",  32'(perr),     32'h0);
    check("v1_ferr",  32'(ferr),     32'h0);
    do_read();
    check("v1_rd_ready", 32'(rx_ready), 32'h0);
    check("v1_rd_hold",  32'(rx_data),  32'hA5);
    do_read();
    check("rd_idle_ready", 32'(rx_ready), 32'h0);
    check("rd_idle_ovf",   32'(ovf),      32'h0);

    // 7-bit, no parity
    send(10'h304, 4'd7, 1'b0, 1'b0);
    tick();
    check("v2_data", 32'(rx_data), 32'h41);
    check("v2_perr", 32'(perr),    32'h0);
    check("v2_ferr", 32'(ferr),    32'h0);
    do_read();

    // data_len=3 clamps to 5-bit, even parity
    send(10'h3A8, 4'd3, 1'b1, 1'b0);
    tick();
    check("v3_data", 32'(rx_data), 32'h15);
    check("v3_perr", 32'(perr),    32'h0);
    check("v3_ferr", 32'(ferr),    32'h0);
    do_read();

    // data_len=15 clamps to 8-bit; parity bad for even
    send(10'h3A5, 4'd15, 1'b1, 1'b0);
    tick();
    check("v4_data", 32'(rx_data), 32'hA5);
    check("v4_perr", 32'(perr),    32'h1);
    do_read();
    send(10'h3A5, 4'd8, 1'b1, 1'b1);
    tick();
    check("v5_perr_odd", 32'(perr), 32'h0);
    do_read();
    send(10'h0A5, 4'd8, 1'b1, 1'b0);
    tick();
    check("v6_ferr", 32'(ferr), 32'h1);
    check("v6_perr", 32'(perr), 32'h0);
    do_read();

    // overrun: 8'h11 then 8'h22 unread (8-bit, no parity)
    send(10'h222, 4'd8, 1'b0, 1'b0);
    tick();
    check("ov1_ovf", 32'(ovf), 32'h0);
    send(10'h244, 4'd8, 1'b0, 1'b0);
    tick();
    check("ov2_data",  32'(rx_data),  32'h22);
    check("ov2_ovf",   32'(ovf),      32'h1);
    check("ov2_ready", 32'(rx_ready), 32'h1);
    do_read();
    check("ov_rd_ready", 32'(rx_ready), 32'h0);
    check("ov_rd_ovf",   32'(ovf),      32'h0);

    // standing overrun cleared by a load coinciding with a read
    send(10'h222, 4'd8, 1'b0, 1'b0);
    tick();
    send(10'h244, 4'd8, 1'b0, 1'b0);
    tick();
    check("ovc_set", 32'(ovf), 32'h1);
    send(10'h266, 4'd8, 1'b0, 1'b0);
    do_read();
    check("ldrd_data",  32'(rx_data),  32'h33);
    check("ldrd_ready", 32'(rx_ready), 32'h1);
    check("ldrd_ovf",   32'(ovf),      32'h0);
    do_read();

    // back-to-back frame_done
    frame_in = 10'h222; data_len = 4'd8; pen = 1'b0; ohel = 1'b0; frame_done = 1'b1;
    tick();
    frame_in = 10'h244;
    tick();
    frame_done = 1'b0;
    check("b2b_first", 32'(rx_data), 32'h11);
    tick();
    check("b2b_second", 32'(rx_data), 32'h22);
    check("b2b_ovf",    32'(ovf),     32'h1);
    do_read();

    // reset with a frame in flight
    send(10'h266, 4'd8, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rsf_data",  32'(rx_data),  32'h0);
    check("rsf_ready", 32'(rx_ready), 32'h0);
    check("rsf_ovf",   32'(ovf),      32'h0);
    tick(); tick();
    check("rsf_noload_ready", 32'(rx_ready), 32'h0);
    check("rsf_noload_data",  32'(rx_data),  32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
